// File: rtl/flap_pkg.sv
// Shared types for the flap sequencer: FSM state encoding, row type and row limits.
package flap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RISE = 2'd1,
    ST_FALL = 2'd2,
    ST_DEAD = 2'd3
  } state_e;

  typedef logic [2:0] row_t;

  localparam row_t ROW_TOP    = 3'd0;
  localparam row_t ROW_BOTTOM = 3'd7;

  // One row towards the top of the screen, stopping at the top row.
  function automatic row_t row_up(input row_t r);
    return (r == ROW_TOP) ? ROW_TOP : row_t'(r - 3'd1);
  endfunction

endpackage

// File: rtl/flap_edge.sv
// Release detector for the flap key: a flap event fires in the cycle the key goes
// from pressed to released, with no extra latency.
module flap_edge
  import flap_pkg::*;
(
  input  logic Clock,
  input  logic Reset,
  input  logic key_i,
  output logic flap_o
);

  localparam logic [0:0] E_RELEASED = 1'b0;
  localparam logic [0:0] E_PRESSED  = 1'b1;

  logic [0:0] pressed_q;
  logic [0:0] pressed_d;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pressed_q <= E_RELEASED;
    end else begin
      pressed_q <= pressed_d;
    end
  end

  always_comb begin
    pressed_d = pressed_q;
    flap_o    = 1'b0;
    case (pressed_q)
      E_RELEASED: begin
        if (key_i) begin
          pressed_d = E_PRESSED;
        end else begin
          pressed_d = E_RELEASED;
        end
      end
      E_PRESSED: begin
        if (key_i) begin
          pressed_d = E_PRESSED;
        end else begin
          pressed_d = E_RELEASED;
          flap_o    = 1'b1;
        end
      end
      default: begin
        pressed_d = E_RELEASED;
        flap_o    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/flap_sequencer.sv
// Flappy-bird style rise/fall/crash sequencer driven by game ticks and flap releases.
// Define FLAP_QUEUE_EN to buffer one flap pressed during a rise.
module flap_sequencer
  import flap_pkg::*;
#(
  parameter int unsigned RISE_TICKS = 2,
  parameter int unsigned FALL_TICKS = 1,
  parameter int unsigned START_ROW  = 3
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       key,
  input  logic       tick,
  input  logic       restart,
  output logic [2:0] bird_row,
  output logic [1:0] state,
  output logic       crashed,
  output logic       flap_ack
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_RISE = ST_RISE;
  localparam logic [1:0] S_FALL = ST_FALL;
  localparam logic [1:0] S_DEAD = ST_DEAD;

  localparam int unsigned RW = $clog2(RISE_TICKS + 1);
  localparam int unsigned FW = (FALL_TICKS > 1) ? $clog2(FALL_TICKS) : 1;
  typedef logic [RW-1:0] rise_cnt_t;
  typedef logic [FW-1:0] fall_cnt_t;

  localparam rise_cnt_t RISE_LOAD = rise_cnt_t'(RISE_TICKS);
  localparam rise_cnt_t RISE_ONE  = rise_cnt_t'(1);
  localparam fall_cnt_t FALL_LAST = fall_cnt_t'(FALL_TICKS - 1);
  localparam row_t      ROW_START = row_t'(START_ROW);

  logic [1:0] state_q, state_d;
  row_t       row_q, row_d;
  rise_cnt_t  rise_q, rise_d;
  fall_cnt_t  fall_q, fall_d;
  logic       pend_q, pend_d;
  logic       ack_q, ack_d;
  logic       crashed_q, crashed_d;
  logic       flap_s;
  logic       q_flap_s;

  flap_edge u_edge (
    .Clock  (Clock),
    .Reset  (Reset),
    .key_i  (key),
    .flap_o (flap_s)
  );

`ifdef FLAP_QUEUE_EN
  assign q_flap_s = flap_s;
`else
  assign q_flap_s = 1'b0;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      row_q     <= ROW_START;
      rise_q    <= '0;
      fall_q    <= '0;
      pend_q    <= 1'b0;
      ack_q     <= 1'b0;
      crashed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      pend_q    <= pend_d;
      ack_q     <= ack_d;
      crashed_q <= crashed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    rise_d  = rise_q;
    fall_d  = fall_q;
    pend_d  = pend_q;
    ack_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        row_d = ROW_START;
        if (flap_s) begin
          state_d = S_RISE;
          rise_d  = RISE_LOAD;
          ack_d   = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RISE: begin
        if (tick) begin
          row_d = row_up(row_q);
          if (rise_q == RISE_ONE) begin
            // A buffered (or simultaneous) flap restarts the climb instead of falling.
            if (pend_q || q_flap_s) begin
              rise_d = RISE_LOAD;
              pend_d = 1'b0;
              ack_d  = 1'b1;
            end else begin
              state_d = S_FALL;
              rise_d  = '0;
              fall_d  = '0;
            end
          end else begin
            rise_d = rise_cnt_t'(rise_q - RISE_ONE);
            pend_d = pend_q | q_flap_s;
          end
        end else begin
          pend_d = pend_q | q_flap_s;
        end
      end
      S_FALL: begin
        if (flap_s) begin
          state_d = S_RISE;
          rise_d  = RISE_LOAD;
          fall_d  = '0;
          ack_d   = 1'b1;
        end else if (tick) begin
          if (fall_q == FALL_LAST) begin
            fall_d = '0;
            if (row_q == ROW_BOTTOM) begin
              state_d = S_DEAD;
            end else begin
              row_d = row_t'(row_q + 3'd1);
            end
          end else begin
            fall_d = fall_cnt_t'(fall_q + fall_cnt_t'(1));
          end
        end else begin
          fall_d = fall_q;
        end
      end
      S_DEAD: begin
        if (restart) begin
          state_d = S_IDLE;
          row_d   = ROW_START;
          rise_d  = '0;
          fall_d  = '0;
          pend_d  = 1'b0;
        end else begin
          state_d = S_DEAD;
        end
      end
      default: begin
        state_d = S_IDLE;
        row_d   = ROW_START;
        rise_d  = '0;
        fall_d  = '0;
        pend_d  = 1'b0;
      end
    endcase
    crashed_d = (state_d == S_DEAD);
  end

  assign bird_row = row_q;
  assign state    = state_q;
  assign crashed  = crashed_q;
  assign flap_ack = ack_q;

endmodule

// File: tb/tb_flap_sequencer.sv
// Self-checking bench for flap_sequencer: event-level reference model checked every
// cycle, plus hand-computed literal checkpoints along a directed scenario.
module tb_flap_sequencer;

  localparam int RT = 2;
  localparam int FT = 1;
  localparam int SR = 3;
`ifdef FLAP_QUEUE_EN
  localparam bit QUEUE = 1'b1;
`else
  localparam bit QUEUE = 1'b0;
`endif

  logic       Clock, Reset, key, tick, restart;
  logic [2:0] bird_row;
  logic [1:0] state;
  logic       crashed, flap_ack;

  int checks   = 0;
  int failures = 0;

  flap_sequencer #(.RISE_TICKS(RT), .FALL_TICKS(FT), .START_ROW(SR)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .key      (key),
    .tick     (tick),
    .restart  (restart),
    .bird_row (bird_row),
    .state    (state),
    .crashed  (crashed),
    .flap_ack (flap_ack)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference model: state as small integers, rows and tick counts as plain arithmetic.
  int m_state, m_row, m_rise_left, m_fall_ticks, m_ack;
  bit m_pend, m_prev, m_valid = 1'b0;

  always @(posedge Clock) begin
    bit flap, want;
    flap = m_prev && !key;
    if (Reset) begin
      m_state = 0; m_row = SR; m_ack = 0; m_rise_left = 0; m_fall_ticks = 0;
      m_pend = 1'b0; m_prev = 1'b0; m_valid = 1'b1;
    end else begin
      m_ack = 0;
      if (m_state == 0) begin
        if (flap) begin m_state = 1; m_rise_left = RT; m_ack = 1; end
      end else if (m_state == 1) begin
        want = m_pend || (QUEUE && flap);
        if (tick) begin
          m_row = (m_row > 0) ? m_row - 1 : 0;
          m_rise_left = m_rise_left - 1;
          if (m_rise_left == 0) begin
            if (want) begin m_rise_left = RT; m_pend = 1'b0; m_ack = 1; end
            else begin m_state = 2; m_fall_ticks = 0; end
          end else m_pend = want;
        end else m_pend = want;
      end else if (m_state == 2) begin
        if (flap) begin m_state = 1; m_rise_left = RT; m_ack = 1; end
        else if (tick) begin
          m_fall_ticks = m_fall_ticks + 1;
          if (m_fall_ticks % FT == 0) begin
            if (m_row == 7) m_state = 3; else m_row = m_row + 1;
          end
        end
      end else begin
        if (restart) begin m_state = 0; m_row = SR; m_pend = 1'b0; end
      end
      m_prev = key;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge Clock) begin
    if (m_valid) begin
      chk("model_state", int'(state), m_state);
      chk("model_row", int'(bird_row), m_row);
      chk("model_crashed", int'(crashed), (m_state == 3) ? 1 : 0);
      chk("model_ack", int'(flap_ack), m_ack);
    end
  end

  task automatic step(input logic k, input logic t, input logic r, input logic rs);
    key = k; tick = t; restart = r; Reset = rs;
    @(posedge Clock);
    #1;
  endtask

  initial begin
    key = 1'b0; tick = 1'b0; restart = 1'b0; Reset = 1'b1;
    #1;
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("rst_state", int'(state), 0);
    chk("rst_row", int'(bird_row), 3);
    chk("rst_crashed", int'(crashed), 0);
    chk("rst_ack", int'(flap_ack), 0);

    // Press for three cycles, release: one flap accepted.
    step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("flap_state", int'(state), 1);
    chk("flap_ack", int'(flap_ack), 1);
    chk("flap_row", int'(bird_row), 3);
    step(0, 0, 0, 0);
    chk("flap_ack_pulse", int'(flap_ack), 0);

    // Two rise ticks then fall.
    step(0, 1, 0, 0);
    chk("rise1_row", int'(bird_row), 2);
    step(0, 1, 0, 0);
    chk("rise2_row", int'(bird_row), 1);
    chk("rise2_state", int'(state), 2);

    // Flap and tick together in FALL: flap wins, row held.
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("tie_row", int'(bird_row), 1);
    chk("tie_state", int'(state), 1);
    chk("tie_ack", int'(flap_ack), 1);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("sat_row", int'(bird_row), 0);
    chk("sat_state", int'(state), 2);

    // Fall to the bottom row, one more tick crashes.
    for (int i = 0; i < 7; i++) step(0, 1, 0, 0);
    chk("bottom_row", int'(bird_row), 7);
    chk("bottom_state", int'(state), 2);
    step(0, 1, 0, 0);
    chk("dead_state", int'(state), 3);
    chk("dead_crashed", int'(crashed), 1);
    chk("dead_row", int'(bird_row), 7);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("dead_flap_state", int'(state), 3);
    chk("dead_flap_ack", int'(flap_ack), 0);
    step(0, 0, 1, 0);
    chk("restart_state", int'(state), 0);
    chk("restart_row", int'(bird_row), 3);
    chk("restart_crashed", int'(crashed), 0);

    // Flap during RISE.
    step(1, 0, 0, 0); step(0, 0, 0, 0);
    step(1, 0, 0, 0); step(0, 0, 0, 0);
    chk("rise_flap_ack", int'(flap_ack), 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("rq_row", int'(bird_row), 1);
    chk("rq_state", int'(state), QUEUE ? 1 : 2);
    chk("rq_ack", int'(flap_ack), QUEUE ? 1 : 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("rq_fall_state", int'(state), 2);
    chk("rq_fall_row", int'(bird_row), QUEUE ? 0 : 3);

    // Reset mid-FALL with tick and key held; then release after reset.
    step(1, 0, 0, 0);
    step(1, 1, 0, 1);
    chk("midrst_state", int'(state), 0);
    chk("midrst_row", int'(bird_row), 3);
    chk("midrst_crashed", int'(crashed), 0);
    chk("midrst_ack", int'(flap_ack), 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("held_flap_ack", int'(flap_ack), 1);
    chk("held_flap_state", int'(state), 1);

    // Pseudo-random tail, checked by the model every cycle.
    for (int i = 0; i < 400; i++) begin
      step(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 2) == 0),
           logic'($urandom_range(0, 7) == 0), logic'($urandom_range(0, 99) == 0));
    end

    @(negedge Clock);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
